// File: rtl/md_pkg.sv
// md_pkg: funct3/state encodings and funct3 decode helpers for the iterative M-extension unit.
package md_pkg;
    typedef enum logic [2:0] {
        MUL    = 3'b000,
        MULH   = 3'b001,
        MULHSU = 3'b010,
        MULHU  = 3'b011,
        DIV    = 3'b100,
        DIVU   = 3'b101,
        REM    = 3'b110,
        REMU   = 3'b111
    } funct3_e;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

    function automatic logic is_div(input logic [2:0] f);
        return f[2];
    endfunction

    function automatic logic is_signed_a(input logic [2:0] f);
        return f[2] ? ~f[0] : (f[1:0] != 2'b11);
    endfunction

    function automatic logic is_signed_b(input logic [2:0] f);
        return f[2] ? ~f[0] : ~f[1];
    endfunction

    // High product half for MULH*, quotient (not remainder) for DIV*
    function automatic logic wants_high_or_quot(input logic [2:0] f);
        return f[2] ? ~f[1] : (f[1:0] != 2'b00);
    endfunction
endpackage

// File: rtl/md_cond_negate.sv
// md_cond_negate: combinational conditional two's-complement negation.
module md_cond_negate #(
    parameter int width_p = 32
) (
    input  logic               i_neg,
    input  logic [width_p-1:0] i_val,
    output logic [width_p-1:0] o_val
);
    assign o_val = i_neg ? -i_val : i_val;
endmodule

// File: rtl/md_iterative_unit.sv
// md_iterative_unit: iterative RV32M/RV64M multiply/divide, one bit per cycle,
// shift-add multiply and restoring divide on operand magnitudes.
module md_iterative_unit
    import md_pkg::*;
#(
    parameter int width_p     = 32,
    parameter bit early_out_p = 1'b1
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               v_i,
    output logic               ready_o,
    input  logic [2:0]         funct3_i,
    input  logic [width_p-1:0] opA_i,
    input  logic [width_p-1:0] opB_i,
    output logic               v_o,
    output logic [width_p-1:0] result_o,
    input  logic               yumi_i
);
    localparam int CW = $clog2(width_p);

    state_e               r_state;
    logic [CW-1:0]        r_cnt;
    logic [2:0]           r_f3;
    logic [2*width_p-1:0] r_a;
    logic [2*width_p-1:0] r_acc;
    logic [width_p-1:0]   r_b;
    logic [width_p-1:0]   r_res;
    logic                 r_neg;
    logic                 r_dbz;
    logic                 r_ovf;

    logic                 w_an;
    logic                 w_bn;
    logic                 w_neg;
    logic                 w_dbz;
    logic                 w_ovf;
    logic                 w_early_spec;
    logic                 w_last;
    logic [width_p-1:0]   w_a_mag;
    logic [width_p-1:0]   w_b_mag;
    logic [width_p-1:0]   w_b_next;
    logic [width_p:0]     w_diff;
    logic [2*width_p-1:0] w_mul_acc;
    logic [2*width_p-1:0] w_div_acc;
    logic [2*width_p-1:0] w_fix_in;
    logic [2*width_p-1:0] w_fix;
    logic [width_p-1:0]   w_calc_res;

    function automatic logic [width_p-1:0] f_special(input logic dbz, input logic quot,
                                                     input logic [width_p-1:0] a);
        return dbz ? (quot ? '1 : a) : (quot ? a : '0);
    endfunction

    assign w_an         = is_signed_a(funct3_i) & opA_i[width_p-1];
    assign w_bn         = is_signed_b(funct3_i) & opB_i[width_p-1];
    assign w_neg        = (is_div(funct3_i) & ~wants_high_or_quot(funct3_i)) ? w_an : (w_an ^ w_bn);
    assign w_dbz        = is_div(funct3_i) & (opB_i == '0);
    assign w_ovf        = is_div(funct3_i) & is_signed_a(funct3_i) & (&opB_i)
                        & (opA_i == {1'b1, {(width_p-1){1'b0}}});
    assign w_early_spec = early_out_p & (w_dbz | w_ovf);

    md_cond_negate #(.width_p(width_p)) u_neg_a (.i_neg(w_an), .i_val(opA_i), .o_val(w_a_mag));
    md_cond_negate #(.width_p(width_p)) u_neg_b (.i_neg(w_bn), .i_val(opB_i), .o_val(w_b_mag));

    assign w_b_next  = r_b >> 1;
    assign w_mul_acc = r_acc + (r_b[0] ? r_a : '0);
    // Remainder lives in the upper half, quotient bits shift in at the bottom
    assign w_diff    = r_acc[2*width_p-1:width_p-1] - {1'b0, r_b};
    assign w_div_acc = w_diff[width_p] ? {r_acc[2*width_p-2:0], 1'b0}
                                       : {w_diff[width_p-1:0], r_acc[width_p-2:0], 1'b1};
    assign w_last    = (r_cnt == CW'(width_p-1))
                     | (early_out_p & ~is_div(r_f3) & (w_b_next == '0));

    // Divide fix-up negates only the selected half so the other half cannot leak a carry
    assign w_fix_in   = is_div(r_f3)
                      ? {{width_p{1'b0}}, wants_high_or_quot(r_f3) ? r_acc[width_p-1:0] : r_acc[2*width_p-1:width_p]}
                      : r_acc;
    md_cond_negate #(.width_p(2*width_p)) u_neg_res (.i_neg(r_neg), .i_val(w_fix_in), .o_val(w_fix));
    assign w_calc_res = (~is_div(r_f3) & wants_high_or_quot(r_f3)) ? w_fix[2*width_p-1:width_p]
                                                                    : w_fix[width_p-1:0];

    assign ready_o  = (r_state == IDLE);
    assign v_o      = (r_state == DONE);
    assign result_o = r_res;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_f3    <= '0;
            r_a     <= '0;
            r_acc   <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_neg   <= 1'b0;
            r_dbz   <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (v_i) begin
                    r_f3    <= funct3_i;
                    r_a     <= {{width_p{1'b0}}, is_div(funct3_i) ? opA_i : w_a_mag};
                    r_b     <= w_b_mag;
                    r_acc   <= is_div(funct3_i) ? {{width_p{1'b0}}, w_a_mag} : '0;
                    r_neg   <= w_neg;
                    r_dbz   <= w_dbz;
                    r_ovf   <= w_ovf;
                    r_res   <= w_early_spec ? f_special(w_dbz, wants_high_or_quot(funct3_i), opA_i) : '0;
                    r_state <= w_early_spec ? DONE : CALC;
                end
                CALC: begin
                    if (is_div(r_f3)) begin
                        r_acc <= w_div_acc;
                    end else begin
                        r_acc <= w_mul_acc;
                        r_a   <= r_a << 1;
                        r_b   <= w_b_next;
                    end
                    r_cnt <= w_last ? '0 : r_cnt + CW'(1);
                    if (w_last) r_state <= FIX;
                end
                FIX: begin
                    r_res   <= (r_dbz | r_ovf) ? f_special(r_dbz, wants_high_or_quot(r_f3), r_a[width_p-1:0])
                                               : w_calc_res;
                    r_state <= DONE;
                end
                DONE: if (yumi_i) begin
                    r_res   <= '0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_md_iterative_unit.sv
// tb_md_iterative_unit: directed vectors against two instances (early_out_p = 0 and 1).
module tb_md_iterative_unit;
    import md_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n, sel, v_req, yumi;
    logic [2:0]  f3;
    logic [31:0] opa, opb;
    logic        ready0, ready1, v0, v1;
    logic [31:0] res0, res1;
    logic        w_ready, w_v;
    logic [31:0] w_res;
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    assign w_ready = sel ? ready1 : ready0;
    assign w_v     = sel ? v1 : v0;
    assign w_res   = sel ? res1 : res0;

    md_iterative_unit #(.width_p(32), .early_out_p(1'b0)) u_d0 (
        .clk_i(clk), .reset_n_i(rst_n), .v_i(v_req & ~sel), .ready_o(ready0),
        .funct3_i(f3), .opA_i(opa), .opB_i(opb), .v_o(v0), .result_o(res0), .yumi_i(yumi & ~sel));

    md_iterative_unit #(.width_p(32), .early_out_p(1'b1)) u_d1 (
        .clk_i(clk), .reset_n_i(rst_n), .v_i(v_req & sel), .ready_o(ready1),
        .funct3_i(f3), .opA_i(opa), .opB_i(opb), .v_o(v1), .result_o(res1), .yumi_i(yumi & sel));

    typedef struct {
        logic        eo;
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Latency counts the accept edge as cycle 1
    task automatic run_op(input logic eo, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] r, output int lat);
        @(negedge clk);
        sel = eo; f3 = f; opa = a; opb = b; v_req = 1'b1;
        @(posedge clk); #1;
        v_req = 1'b0;
        lat = 1;
        while (!w_v && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        r = w_res;
    endtask

    task automatic take();
        @(negedge clk);
        yumi = 1'b1;
        @(posedge clk); #1;
        yumi = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] r;
        int          lat;
        logic        saw;
        rst_n = 1'b0; sel = 1'b0; v_req = 1'b0; yumi = 1'b0; f3 = '0; opa = '0; opb = '0;

        vecs.push_back('{1'b0, MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34});
        vecs.push_back('{1'b0, MULH,   32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 34});
        vecs.push_back('{1'b0, MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34});
        vecs.push_back('{1'b1, MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34});
        vecs.push_back('{1'b1, MULH,   32'h80000000, 32'h80000000, 32'h40000000, 34});
        vecs.push_back('{1'b1, MULH,   32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 4});
        vecs.push_back('{1'b1, MUL,    32'd5,        32'd6,        32'd30,       5});
        vecs.push_back('{1'b1, MUL,    32'd3,        32'd1,        32'd3,        3});
        vecs.push_back('{1'b1, MUL,    32'h1234,     32'd0,        32'd0,        3});
        vecs.push_back('{1'b0, DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34});
        vecs.push_back('{1'b0, REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34});
        vecs.push_back('{1'b0, DIV,    32'hFFFFFFF9, 32'hFFFFFFFE, 32'd3,        34});
        vecs.push_back('{1'b0, REM,    32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 34});
        vecs.push_back('{1'b1, DIVU,   32'd100,      32'd7,        32'd14,       34});
        vecs.push_back('{1'b1, REMU,   32'd100,      32'd7,        32'd2,        34});
        vecs.push_back('{1'b0, DIVU,   32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 34});
        vecs.push_back('{1'b1, DIV,    32'd5,        32'd0,        32'hFFFFFFFF, 1});
        vecs.push_back('{1'b1, REM,    32'd5,        32'd0,        32'd5,        1});
        vecs.push_back('{1'b0, DIV,    32'd5,        32'd0,        32'hFFFFFFFF, 34});
        vecs.push_back('{1'b0, REM,    32'd5,        32'd0,        32'd5,        34});
        vecs.push_back('{1'b1, DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1});
        vecs.push_back('{1'b1, REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        1});
        vecs.push_back('{1'b0, DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 34});
        vecs.push_back('{1'b0, REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        34});

        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready0", 32'(ready0), 32'd1);
        chk("rst_v0",     32'(v0),     32'd0);
        chk("rst_res0",   res0,        32'd0);
        chk("rst_ready1", 32'(ready1), 32'd1);
        chk("rst_v1",     32'(v1),     32'd0);
        chk("rst_res1",   res1,        32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            run_op(vecs[i].eo, vecs[i].f, vecs[i].a, vecs[i].b, r, lat);
            chk($sformatf("vec%0d_result", i), r, vecs[i].exp);
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
            take();
        end

        // Backpressure: hold the result while v_i pulses are ignored
        run_op(1'b0, DIVU, 32'd100, 32'd7, r, lat);
        chk("bp_result", r, 32'd14);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            v_req = k[0]; f3 = MUL; opa = 32'(k); opb = 32'd3;
            @(posedge clk); #1;
            chk("bp_hold_res",   w_res,          32'd14);
            chk("bp_hold_ready", 32'(w_ready),   32'd0);
            chk("bp_hold_v",     32'(w_v),       32'd1);
        end
        @(negedge clk);
        v_req = 1'b1; yumi = 1'b1;
        @(posedge clk); #1;
        v_req = 1'b0; yumi = 1'b0;
        chk("bp_ready_after_yumi", 32'(w_ready), 32'd1);
        chk("bp_v_after_yumi",     32'(w_v),     32'd0);
        chk("bp_res_after_yumi",   w_res,        32'd0);
        @(posedge clk); #1;
        chk("bp_no_same_cycle_accept", 32'(w_ready), 32'd1);

        // Reset in CALC cycle 5 aborts the operation
        @(negedge clk);
        sel = 1'b0; f3 = MUL; opa = 32'd7; opb = 32'd9; v_req = 1'b1;
        @(posedge clk); #1;
        v_req = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_v",     32'(v0),     32'd0);
        chk("abort_ready", 32'(ready0), 32'd1);
        chk("abort_res",   res0,        32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        saw = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (v0) saw = 1'b1;
        end
        chk("abort_no_result", 32'(saw), 32'd0);

        // Post-reset op with spurious yumi while v_o is low
        @(negedge clk);
        f3 = DIVU; opa = 32'd9; opb = 32'd3; v_req = 1'b1; yumi = 1'b1;
        @(posedge clk); #1;
        v_req = 1'b0;
        lat = 1;
        while (!w_v && lat < 100) begin
            if (lat == 3) yumi = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        yumi = 1'b0;
        chk("post_rst_divu_result",  w_res,    32'd3);
        chk("post_rst_divu_latency", 32'(lat), 32'd34);
        take();
        chk("post_rst_ready", 32'(w_ready), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
